// File: rtl/reserved_slot_manager.sv
// Reserved parking slot manager: live occupancy bitmap with entry/exit checking,
// valid/ready request and response channels, and a timed gate-open pulse.
module reserved_slot_manager #(
    parameter int N_SLOTS     = 32,
    parameter int FLAT_W      = $clog2(N_SLOTS + 1),
    parameter int GATE_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_is_exit,
    input  logic [FLAT_W-1:0]                req_flat,
    input  logic                             clear_all,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [1:0]                       resp_code,
    output logic [FLAT_W-1:0]                resp_flat,
    output logic [N_SLOTS-1:0]               occupied,
    output logic [$clog2(N_SLOTS+1)-1:0]     occ_count,
    output logic                             full,
    output logic                             gate_open
);

    localparam int IDX_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int CNT_W  = $clog2(N_SLOTS + 1);
    localparam int GATE_W = $clog2(GATE_CYCLES + 1);

    localparam logic [1:0] CODE_OK_ENTRY = 2'd0;
    localparam logic [1:0] CODE_OK_EXIT  = 2'd1;
    localparam logic [1:0] CODE_ERR_ST   = 2'd2;
    localparam logic [1:0] CODE_ERR_FLAT = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  req_exit_p0;
    logic [FLAT_W-1:0]     req_flat_p0;
    logic [1:0]            resp_code_p1;
    logic [FLAT_W-1:0]     resp_flat_p1;
    logic                  vld_p1;
    logic [N_SLOTS-1:0]    occ_q;
    logic [CNT_W-1:0]      occ_cnt_q;
    logic [GATE_W-1:0]     gate_cnt_q;

    logic                  accept;
    logic                  flat_ok;
    logic [IDX_W-1:0]      slot_idx;
    logic [N_SLOTS-1:0]    slot_mask;
    logic                  slot_set;
    logic                  chk_ok;
    logic [1:0]            chk_code;

    // Clear has priority over a request arriving in the same IDLE cycle.
    assign req_ready  = (state_q == IDLE) && !clear_all && !rst;
    assign accept     = req_valid && req_ready;
    assign vld_p1     = (state_q == RESP);

    assign resp_valid = vld_p1;
    assign resp_code  = resp_code_p1;
    assign resp_flat  = resp_flat_p1;
    assign occupied   = occ_q;
    assign occ_count  = occ_cnt_q;
    assign full       = (occ_cnt_q == CNT_W'(N_SLOTS));
    assign gate_open  = (gate_cnt_q != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CHECK;
            CHECK:   state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range flats produce an all-zero mask, so they never touch the bitmap.
    always_comb begin
        flat_ok   = (req_flat_p0 != '0) && (req_flat_p0 <= FLAT_W'(N_SLOTS));
        slot_idx  = IDX_W'(req_flat_p0 - FLAT_W'(1));
        slot_mask = '0;
        if (flat_ok) slot_mask[slot_idx] = 1'b1;
        slot_set  = |(occ_q & slot_mask);
        chk_ok    = 1'b0;
        chk_code  = CODE_ERR_FLAT;
        if (!flat_ok) begin
            chk_code = CODE_ERR_FLAT;
        end else if (req_exit_p0 != slot_set) begin
            chk_code = CODE_ERR_ST;
        end else begin
            chk_ok   = 1'b1;
            chk_code = req_exit_p0 ? CODE_OK_EXIT : CODE_OK_ENTRY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // p0: request capture in IDLE; p1: check result and bitmap update in CHECK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_exit_p0  <= 1'b0;
            req_flat_p0  <= '0;
            resp_code_p1 <= '0;
            resp_flat_p1 <= '0;
            occ_q        <= '0;
            occ_cnt_q    <= '0;
        end else begin
            if (accept) begin
                req_exit_p0 <= req_is_exit;
                req_flat_p0 <= req_flat;
            end
            if (state_q == IDLE && clear_all) begin
                occ_q     <= '0;
                occ_cnt_q <= '0;
            end else if (state_q == CHECK && chk_ok) begin
                occ_q     <= occ_q ^ slot_mask;
                occ_cnt_q <= req_exit_p0 ? occ_cnt_q - CNT_W'(1) : occ_cnt_q + CNT_W'(1);
            end
            if (state_q == CHECK) begin
                resp_code_p1 <= chk_code;
                resp_flat_p1 <= req_flat_p0;
            end
        end
    end

    // A new OK reloads the window so back-to-back successes keep the gate open.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt_q <= '0;
        end else if (state_q == CHECK && chk_ok) begin
            gate_cnt_q <= GATE_W'(GATE_CYCLES);
        end else if (gate_cnt_q != '0) begin
            gate_cnt_q <= gate_cnt_q - GATE_W'(1);
        end
    end

endmodule
